// File: rtl/hsem_ine_mc.sv
// hsem_ine_mc: per-core sticky error, error counter, software interrupt and pending/pulse interrupt controller for HSEM
module hsem_ine_mc #(
  parameter int NUM_CORES    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int SEMERR_WIDTH = 4,
  parameter int ERRCNT_WIDTH = 8,
  parameter int CORE_W       = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic                             wr_en,
  input  logic                             rd_en,
  input  logic [CORE_W-1:0]                core_sel,
  input  logic [2:0]                       reg_sel,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             rdata_vld,
  input  logic [NUM_CORES*SEMERR_WIDTH-1:0] semerr,
  output logic [NUM_CORES-1:0]             intr,
  output logic [NUM_CORES-1:0]             intr_pend
);
  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_e;
  logic [DATA_WIDTH-1:0] rv [NUM_CORES];
  logic [DATA_WIDTH-1:0] rd_val, rdata_q, rdata_d;
  logic                  rdata_vld_q, rdata_vld_d;
  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    logic                    sel, w_err, w_cnt, w_sw, w_en, w_ack, ev;
    logic [SEMERR_WIDTH-1:0] se, err_q, err_d;
    logic [ERRCNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   sw_q, sw_d;
    logic [2:0]              en_q, en_d;
    logic                    pend_q, pend_d;
    state_e                  state_q, state_d;
    assign se  = semerr[c*SEMERR_WIDTH +: SEMERR_WIDTH];
    assign sel = wr_en && core_sel == CORE_W'(c);
    always_comb begin
      w_err   = sel && reg_sel == 3'd0;
      w_cnt   = sel && reg_sel == 3'd1;
      w_sw    = sel && reg_sel == 3'd2;
      w_en    = sel && reg_sel == 3'd3;
      w_ack   = sel && reg_sel == 3'd4;
      ev      = (en_q[0] && |se) || (en_q[1] && w_sw && |wdata);
      err_d   = (err_q & ~(w_err ? wdata[SEMERR_WIDTH-1:0] : '0)) | se;
      cnt_d   = w_cnt ? ERRCNT_WIDTH'(|se) : (|se && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
      sw_d    = w_sw ? wdata : w_ack ? '0 : sw_q;
      en_d    = w_en ? wdata[2:0] : en_q;
      pend_d  = ev || (pend_q && !w_ack);
      // events arriving while HOLD are coalesced into the existing pending
      state_d = state_q == IDLE  ? (ev ? PULSE : IDLE) :
                state_q == PULSE ? ((w_ack && !ev) ? IDLE : HOLD) :
                                   (w_ack ? (ev ? PULSE : IDLE) : HOLD);
    end
    always_ff @(posedge hclk) begin
      if (!hresetn) begin
        err_q   <= '0;
        cnt_q   <= '0;
        sw_q    <= '0;
        en_q    <= 3'b011;
        pend_q  <= 1'b0;
        state_q <= IDLE;
      end else begin
        err_q   <= err_d;
        cnt_q   <= cnt_d;
        sw_q    <= sw_d;
        en_q    <= en_d;
        pend_q  <= pend_d;
        state_q <= state_d;
      end
    end
    assign intr[c]      = en_q[2] ? state_q == PULSE : pend_q;
    assign intr_pend[c] = pend_q;
    assign rv[c] = reg_sel == 3'd0 ? DATA_WIDTH'(err_q) :
                   reg_sel == 3'd1 ? DATA_WIDTH'(cnt_q) :
                   reg_sel == 3'd2 ? sw_q :
                   reg_sel == 3'd3 ? DATA_WIDTH'(en_q) : '0;
  end
  // out-of-range core indices match no core and read as zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (core_sel == CORE_W'(i)) rd_val = rv[i];
    rdata_d     = rd_en ? rd_val : rdata_q;
    rdata_vld_d = rd_en;
  end
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
    end else begin
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
    end
  end
  assign rdata     = rdata_q;
  assign rdata_vld = rdata_vld_q;
endmodule

// File: tb/tb_hsem_ine_mc.sv
// tb_hsem_ine_mc: scoreboard bench for hsem_ine_mc with three cores
module tb_hsem_ine_mc;
  logic        hclk = 1'b0, hresetn = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [1:0]  core_sel = '0;
  logic [2:0]  reg_sel = '0;
  logic [31:0] wdata = '0, rdata;
  logic        rdata_vld;
  logic [11:0] semerr = '0;
  logic [2:0]  intr, intr_pend;
  logic [31:0] exp_q[$];
  int          n_cmp = 0, n_err = 0;

  hsem_ine_mc #(.NUM_CORES(3), .DATA_WIDTH(32), .SEMERR_WIDTH(4), .ERRCNT_WIDTH(8)) dut (
    .hclk(hclk), .hresetn(hresetn), .wr_en(wr_en), .rd_en(rd_en), .core_sel(core_sel),
    .reg_sel(reg_sel), .wdata(wdata), .rdata(rdata), .rdata_vld(rdata_vld),
    .semerr(semerr), .intr(intr), .intr_pend(intr_pend)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic wr(input int c, input int r, input logic [31:0] d);
    core_sel = 2'(c); reg_sel = 3'(r); wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int c, input int r, input logic [31:0] e);
    core_sel = 2'(c); reg_sel = 3'(r); rd_en = 1'b1;
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
    chk("rd_vld", {31'd0, rdata_vld}, 32'd1);
  endtask

  always @(negedge hclk)
    if (rdata_vld) begin
      if (exp_q.size() == 0) chk("rd_unexp", {31'd0, rdata_vld}, 32'd0);
      else chk("rdata", rdata, exp_q.pop_front());
    end

  initial begin
    repeat (3) tick();
    hresetn = 1'b1;
    chk("rst_intr", {29'd0, intr}, 0);
    chk("rst_pend", {29'd0, intr_pend}, 0);
    chk("rst_vld", {31'd0, rdata_vld}, 0);
    chk("rst_rdata", rdata, 0);
    rd(1, 3, 32'h3);
    // core 0 level mode
    semerr = 12'h002; tick(); semerr = '0;
    chk("lvl_intr", {31'd0, intr[0]}, 1);
    chk("lvl_pend", {29'd0, intr_pend}, 3'b001);
    rd(0, 0, 32'h2);
    rd(0, 1, 32'h1);
    wr(0, 0, 32'h2);
    rd(0, 0, 32'h0);
    chk("lvl_hold", {31'd0, intr[0]}, 1);
    wr(0, 4, 32'h0);
    chk("lvl_ack", {29'd0, intr}, 0);
    // core 1 pulse mode
    wr(1, 3, 32'h7);
    wr(1, 2, 32'hA5);
    chk("pls_on", {29'd0, intr}, 3'b010);
    chk("pls_pend", {29'd0, intr_pend}, 3'b010);
    tick();
    chk("pls_off", {29'd0, intr}, 0);
    wr(1, 2, 32'h5A);
    chk("pls_coal", {29'd0, intr}, 0);
    chk("pls_coal_p", {31'd0, intr_pend[1]}, 1);
    rd(1, 2, 32'h5A);
    rd(1, 3, 32'h7);
    wr(1, 4, 32'h0);
    chk("pls_ack", {31'd0, intr_pend[1]}, 0);
    rd(1, 2, 32'h0);
    wr(1, 2, 32'h0);
    chk("sw_zero", {29'd0, intr_pend}, 0);
    // ack colliding with an error event on core 0
    wr(0, 3, 32'h7);
    semerr = 12'h001; tick(); semerr = '0;
    chk("c0_pls", {31'd0, intr[0]}, 1);
    tick();
    chk("c0_hold", {31'd0, intr[0]}, 0);
    semerr = 12'h001; core_sel = 2'd0; reg_sel = 3'd4; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; semerr = '0;
    chk("coll_pend", {31'd0, intr_pend[0]}, 1);
    chk("coll_pls", {31'd0, intr[0]}, 1);
    tick();
    chk("coll_pls_end", {31'd0, intr[0]}, 0);
    wr(0, 4, 32'h0);
    chk("coll_ack", {29'd0, intr_pend}, 0);
    // core 2: error interrupts disabled, counter saturation
    wr(2, 3, 32'h0);
    semerr = 12'h100;
    repeat (300) tick();
    chk("sat_nopend", {29'd0, intr_pend}, 0);
    rd(2, 1, 32'hFF);
    wr(2, 1, 32'h0);
    semerr = '0;
    rd(2, 1, 32'h1);
    rd(2, 0, 32'h1);
    // out-of-range core and reserved registers
    wr(3, 2, 32'hFF);
    wr(3, 3, 32'h0);
    wr(1, 5, 32'hFFFF);
    rd(3, 2, 32'h0);
    rd(3, 3, 32'h0);
    rd(1, 5, 32'h0);
    rd(1, 4, 32'h0);
    rd(0, 2, 32'h0);
    rd(2, 2, 32'h0);
    rd(0, 3, 32'h7);
    chk("oor_pend", {29'd0, intr_pend}, 0);
    // read and write of the same register in one cycle, then reset during a pulse
    core_sel = 2'd0; reg_sel = 3'd2; wdata = 32'h33; wr_en = 1'b1; rd_en = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_pls", {31'd0, intr[0]}, 1);
    hresetn = 1'b0; rd_en = 1'b1; core_sel = 2'd1; reg_sel = 3'd3;
    tick();
    rd_en = 1'b0;
    chk("mrst_intr", {29'd0, intr}, 0);
    chk("mrst_pend", {29'd0, intr_pend}, 0);
    chk("mrst_vld", {31'd0, rdata_vld}, 0);
    chk("mrst_rdata", rdata, 0);
    hresetn = 1'b1;
    rd(0, 2, 32'h0);
    rd(0, 3, 32'h3);
    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
